// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI responder.
package spi_responder_pkg;

  typedef logic [2:0] bit_cnt_t;

  localparam bit_cnt_t FIRST_BIT = 3'd0;
  localparam bit_cnt_t LAST_BIT  = 3'd7;

endpackage

// File: rtl/spi_responder_sync_edge.sv
// N-flop synchronizer with one history flop for rise/fall detection.
module spi_sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetq,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [N-1:0] chain;
  logic         hist;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      chain <= {N{RST_VAL}};
      hist  <= RST_VAL;
    end else begin
      chain <= {chain[N-2:0], din};
      hist  <= chain[N-1];
    end
  end

  assign dout = chain[N-1];
  assign rise = dout & ~hist;
  assign fall = ~dout & hist;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: bytes in via rx_data/valid/rd, replies queued via wr/tx_data.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter logic [7:0] FILL = 8'hFF,
  parameter int         SYNC = 2
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       tx_full,
  output logic       overrun,
  output logic       active
);

  logic            sck_s, sck_rise, sck_fall;
  logic            cs_s, cs_rise, cs_fall;
  logic [SYNC-1:0] mosi_chain;
  logic            mosi_s;

  bit_cnt_t   bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] tx_hold;

  logic sck_ok, byte_done, load, shift;

  spi_sync_edge #(.N(SYNC), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .resetq(resetq), .din(sck),
    .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.N(SYNC), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .resetq(resetq), .din(cs_n),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi only needs the same delay as sck so data stays aligned with its edge
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) mosi_chain <= '0;
    else         mosi_chain <= {mosi_chain[SYNC-2:0], mosi};
  end
  assign mosi_s = mosi_chain[SYNC-1];

  // A CS rise wins over an SCK edge seen in the same cycle
  always_comb begin
    sck_ok    = active & ~cs_rise;
    byte_done = sck_ok & sck_rise & (bit_cnt == LAST_BIT);
    load      = cs_fall | (sck_ok & sck_fall & (bit_cnt == FIRST_BIT));
    shift     = sck_ok & sck_fall & (bit_cnt != FIRST_BIT);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      active   <= 1'b0;
      bit_cnt  <= FIRST_BIT;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_hold  <= '0;
      tx_full  <= 1'b0;
      rx_data  <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (cs_fall) begin
        active  <= 1'b1;
        bit_cnt <= FIRST_BIT;
      end else if (cs_rise) begin
        active  <= 1'b0;
        bit_cnt <= FIRST_BIT;
      end else if (sck_ok && sck_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (load) begin
        tx_shift <= tx_full ? tx_hold : FILL;
        if (tx_full) tx_full <= 1'b0;
      end else if (shift) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // Placed after the load so a coincident wr leaves the new byte queued
      if (wr) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end

      if (byte_done) begin
        rx_data <= {rx_shift, mosi_s};
        valid   <= 1'b1;
        if (valid && !rd) overrun <= 1'b1;
      end else if (rd) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign miso    = tx_shift[7];
  assign miso_oe = active;

  logic unused_sync;
  assign unused_sync = sck_s ^ cs_s;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder acting as an SPI mode-0 initiator at clk/8.
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       resetq;
  logic       sck, mosi, cs_n;
  logic       miso, miso_oe;
  logic       rd, wr;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       valid, tx_full, overrun, active;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] got;

  spi_responder dut (
    .clk(clk), .resetq(resetq), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .rd(rd), .wr(wr), .tx_data(tx_data),
    .rx_data(rx_data), .valid(valid), .tx_full(tx_full), .overrun(overrun),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Half SCK period (4 clk); optional strobe lands on the clk edge that acts
  // on the SCK edge driven just before (2 sync flops, then the acting edge).
  task automatic half(input logic do_rd, input logic do_wr, input logic [7:0] d);
    repeat (2) @(negedge clk);
    rd = do_rd; wr = do_wr; tx_data = d;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic end_frame();
    sck  = 1'b0;
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    @(negedge clk); wr = 1'b1; tx_data = d;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] out_b, input int nbits, input logic rd_done,
                      input logic wr_fall, input logic [7:0] wr_b,
                      input logic final_fall, output logic [7:0] in_b);
    in_b = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = out_b[7-i];
      repeat (4) @(negedge clk);
      in_b[7-i] = miso;
      sck = 1'b1;
      half(rd_done && i == 7, 1'b0, 8'h00);
      if (i < nbits - 1 || final_fall) begin
        sck = 1'b0;
        half(1'b0, wr_fall && i == 7, wr_b);
      end
    end
  endtask

  initial begin
    resetq = 1'b0; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    rd = 1'b0; wr = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_active", active, 0);
    resetq = 1'b1;
    repeat (3) @(negedge clk);

    // single byte, nothing queued
    chk("t1_oe_idle", miso_oe, 0);
    start_frame();
    chk("t1_oe_frame", miso_oe, 1);
    chk("t1_active", active, 1);
    xfer(8'hA5, 8, 1'b0, 1'b0, 8'h00, 1'b1, got);
    chk("t1_miso", got, 8'hFF);
    end_frame();
    chk("t1_rx", rx_data, 8'hA5);
    chk("t1_valid", valid, 1);
    chk("t1_oe_end", miso_oe, 0);
    chk("t1_active_end", active, 0);

    // queued reply, two bytes, overrun
    pulse_wr(8'h3C);
    chk("t2_full_pre", tx_full, 1);
    start_frame();
    chk("t2_full_cs", tx_full, 0);
    xfer(8'h12, 8, 1'b0, 1'b0, 8'h00, 1'b1, got);
    chk("t2_miso0", got, 8'h3C);
    xfer(8'h34, 8, 1'b0, 1'b0, 8'h00, 1'b1, got);
    chk("t2_miso1", got, 8'hFF);
    end_frame();
    chk("t2_rx", rx_data, 8'h34);
    chk("t2_overrun", overrun, 1);
    pulse_rd();
    chk("t2_valid_rd", valid, 0);
    chk("t2_overrun_rd", overrun, 0);
    chk("t2_rx_held", rx_data, 8'h34);

    // rd coincident with second byte completion
    start_frame();
    xfer(8'h56, 8, 1'b0, 1'b0, 8'h00, 1'b1, got);
    xfer(8'h78, 8, 1'b1, 1'b0, 8'h00, 1'b1, got);
    end_frame();
    chk("t3_valid", valid, 1);
    chk("t3_overrun", overrun, 0);
    chk("t3_rx", rx_data, 8'h78);

    // wr coincident with boundary reload; CS rise swallows the final SCK fall
    pulse_rd();
    start_frame();
    xfer(8'h9A, 8, 1'b0, 1'b1, 8'h55, 1'b1, got);
    chk("t4_miso0", got, 8'hFF);
    xfer(8'hBC, 8, 1'b0, 1'b0, 8'h00, 1'b0, got);
    chk("t4_miso1", got, 8'hFF);
    end_frame();
    chk("t4_full", tx_full, 1);
    pulse_rd();
    start_frame();
    chk("t4_full_cs", tx_full, 0);
    xfer(8'h00, 8, 1'b0, 1'b0, 8'h00, 1'b1, got);
    chk("t4_miso_next", got, 8'h55);
    end_frame();
    chk("t4_rx", rx_data, 8'h00);

    // partial byte discarded
    pulse_rd();
    start_frame();
    xfer(8'hF0, 5, 1'b0, 1'b0, 8'h00, 1'b1, got);
    end_frame();
    chk("t5_valid", valid, 0);
    chk("t5_rx_held", rx_data, 8'h00);
    chk("t5_oe", miso_oe, 0);
    start_frame();
    xfer(8'h81, 8, 1'b0, 1'b0, 8'h00, 1'b1, got);
    end_frame();
    chk("t5_rx", rx_data, 8'h81);
    chk("t5_valid2", valid, 1);

    // async reset mid-byte
    start_frame();
    pulse_wr(8'h77);
    xfer(8'h6B, 3, 1'b0, 1'b0, 8'h00, 1'b1, got);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_full_pre", tx_full, 1);
    resetq = 1'b0;
    #1;
    chk("t6_miso", miso, 0);
    chk("t6_oe", miso_oe, 0);
    chk("t6_rx", rx_data, 0);
    chk("t6_valid", valid, 0);
    chk("t6_full", tx_full, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_active", active, 0);
    sck = 1'b0; cs_n = 1'b1;
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    repeat (3) @(negedge clk);
    start_frame();
    xfer(8'hC3, 8, 1'b0, 1'b0, 8'h00, 1'b1, got);
    chk("t6_miso_after", got, 8'hFF);
    end_frame();
    chk("t6_rx_after", rx_data, 8'hC3);
    chk("t6_valid_after", valid, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI mode-0 target (responder) for the j1a PMOD header.
- An external SPI initiator clocks bytes in and out. The j1 reads received bytes and queues reply bytes through the same rd/wr strobe style as the UART.
- This is the opposite end of the bit-banged flash SPI initiator on PIOS.
- Sits in top beside the UART. It is decoded on its own io_addr_ bit; status bits are merged into io_din.

Parameters:
FILL, 8'hFF, byte shifted out on MISO when no reply byte is queued
SYNC, 2, synchronizer flops on sck/mosi/cs_n (minimum 2)

Ports:
clk  input  1  system clock (12 MHz)
resetq  input  1  asynchronous active-low reset
sck  input  1  SPI clock from initiator, asynchronous
mosi  input  1  SPI data from initiator, asynchronous
cs_n  input  1  SPI select, active low, asynchronous
miso  output  1  SPI data to initiator
miso_oe  output  1  drive enable for miso pad (1 = drive)
rd  input  1  one-cycle strobe: j1 consumed rx_data
wr  input  1  one-cycle strobe: queue tx_data as next reply
tx_data  input  8  reply byte, sampled when wr=1
rx_data  output  8  last completed received byte
valid  output  1  rx_data holds an unread byte
tx_full  output  1  reply holding register occupied
overrun  output  1  sticky: a byte completed while valid was already 1
active  output  1  synchronized cs_n is low

Behaviour:
- Clock and reset: one clock domain. resetq is asynchronous and active-low; every flop clears on resetq=0.
- Reset values:
  - miso=0, miso_oe=0, rx_data=0, valid=0, tx_full=0, overrun=0, active=0.
  - Bit counter = 0; both shift registers = 0.
  - Synchronizer history: sck=0, cs_n=1.
- Input synchronization:
  - sck, mosi and cs_n each pass through SYNC flops, plus one history flop on sck and cs_n.
  - Edges are detected as the synchronized value differing from the history flop.
  - Supported SCK ≤ clk/8 (1.5 MHz at 12 MHz). Initiator must hold CS low ≥ SYNC+2 clk before the first SCK rise.
- Frame start (cs_n falling, synchronized):
  - active=1, miso_oe=1, bit_cnt=0.
  - tx_shift is loaded with tx_hold if tx_full, else FILL; tx_full clears if the load used tx_hold.
  - miso = tx_shift[7] at all times (MSB first).
- SCK rising edge while active:
  - rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7->0).
- Byte completion (rising edge that wraps bit_cnt to 0):
  - rx_data <= the completed 8-bit value; valid <= 1.
  - If valid was already 1 and rd is not asserted this cycle, overrun <= 1. The new byte overwrites rx_data.
- SCK falling edge while active:
  - If bit_cnt==0 (byte boundary), reload tx_shift from tx_hold/FILL exactly as at frame start.
  - Otherwise tx_shift <= tx_shift<<1.
- Edges while inactive: SCK edges with active=0 are ignored.
- rd strobe: clears valid and overrun; rx_data is held.
  - rd in the same cycle as byte completion: valid ends at 1 and overrun is unchanged.
- wr strobe: tx_hold <= tx_data; tx_full <= 1. A wr while tx_full=1 silently replaces the queued byte.
  - wr in the same cycle as a tx_shift load: the load takes the old tx_hold (or FILL); the new byte lands in tx_hold and tx_full ends at 1.
- Frame end (cs_n rising, synchronized):
  - active=0, miso_oe=0, bit_cnt=0. A partial rx byte is discarded (valid unchanged).
  - tx_hold/tx_full are kept, so a byte queued but unsent goes out at the next frame.
- Asynchronous reset mid-frame: all state returns to the reset values above. The initiator must restart with a fresh CS fall.
- Latency: valid rises 1 clk after the synchronized 8th SCK rise, i.e. ≤ SYNC+2 clk after the pin edge.

Decomposition:
- No package needed. FILL and SYNC stay local parameters; the top-level io_addr_ bit and the status bit layout {overrun, active, tx_full, valid} belong with top's IO port table.
- One natural sub-module: spi_sync_edge (N-flop synchronizer plus rise/fall detect), instantiated for sck and cs_n. mosi uses its data path only.

Test Plan:
- Reset, then a 1-byte frame with mosi=8'hA5 and no wr -> rx_data=8'hA5, valid=1; miso carries 8'hFF; miso_oe=1 only while CS is low.
- wr tx_data=8'h3C before CS fall, 2-byte frame sending 8'h12,8'h34 -> miso bytes 8'h3C then 8'hFF; tx_full clears at CS fall; rx_data=8'h34, overrun=1; rd -> valid=0, overrun=0.
- 2-byte frame with rd pulsed in the exact cycle the second byte completes -> valid=1, overrun=0, rx_data=second byte.
- wr 8'h55 coincident with the falling-edge reload at the byte-1 boundary -> byte 2 shifts FILL, 8'h55 remains queued with tx_full=1 and is sent first in the next frame.
- CS raised after 5 bits of 8'hF0 -> valid unchanged, bit_cnt=0; next full frame of 8'h81 -> rx_data=8'h81.
- resetq pulsed low mid-byte -> all outputs return to reset values immediately (asynchronously); the following frame receives correctly.
